// File: rtl/data_table_rd_arbiter.sv
// Round-robin arbiter sharing the data-table RAM read port between search
// engines, with a fixed-latency return pipe that routes data-valid strobes.
module data_table_rd_arbiter #(
  parameter int ENGINES_CNT = 3,
  parameter int RAM_LATENCY = 2,
  parameter int A_WIDTH     = 10,
  parameter int D_WIDTH     = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [ENGINES_CNT-1:0]          req_i,
  input  logic [ENGINES_CNT*A_WIDTH-1:0]  addr_i,
  output logic [ENGINES_CNT-1:0]          gnt_o,
  input  logic                            wr_busy_i,
  output logic                            rd_en_o,
  output logic [A_WIDTH-1:0]              rd_addr_o,
  input  logic [D_WIDTH-1:0]              rd_data_i,
  output logic [D_WIDTH-1:0]              rd_data_o,
  output logic [ENGINES_CNT-1:0]          rd_data_val_o,
  output logic [$clog2(RAM_LATENCY+1)-1:0] inflight_o,
  output logic                            idle_o
);

  localparam int ID_W  = (ENGINES_CNT > 1) ? $clog2(ENGINES_CNT) : 1;
  localparam int CNT_W = $clog2(RAM_LATENCY + 1);

  logic [ID_W-1:0]  last_q;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;

  logic             pipe_val_q [RAM_LATENCY];
  logic [ID_W-1:0]  pipe_id_q  [RAM_LATENCY];
  logic             ret_val;
  logic [ID_W-1:0]  ret_id;

  logic [CNT_W-1:0] inflight_q;

  // Scan starts just past the last winner so every requester gets a turn.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    gnt_o   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    cand    = '0;
    if (!wr_busy_i) begin
      for (int s = 1; s <= ENGINES_CNT; s++) begin
        idx  = (int'(last_q) + s) % ENGINES_CNT;
        cand = ID_W'(idx);
        if (!gnt_any && req_i[cand]) begin
          gnt_any     = 1'b1;
          gnt_id      = cand;
          gnt_o[cand] = 1'b1;
        end
      end
    end
  end

  assign rd_en_o = gnt_any;

  always_comb begin
    rd_addr_o = '0;
    for (int k = 0; k < ENGINES_CNT; k++) begin
      if (gnt_o[k]) begin
        rd_addr_o = addr_i[k*A_WIDTH +: A_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= ID_W'(ENGINES_CNT - 1);
    end else if (rd_en_o) begin
      last_q <= gnt_id;
    end
  end

  // The return pipe never stalls; a write phase only blocks new issues.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        pipe_val_q[i] <= 1'b0;
        pipe_id_q[i]  <= '0;
      end
    end else begin
      pipe_val_q[0] <= rd_en_o;
      pipe_id_q[0]  <= gnt_id;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_val_q[i] <= pipe_val_q[i-1];
        pipe_id_q[i]  <= pipe_id_q[i-1];
      end
    end
  end

  assign ret_val   = pipe_val_q[RAM_LATENCY-1];
  assign ret_id    = pipe_id_q[RAM_LATENCY-1];
  assign rd_data_o = rd_data_i;

  always_comb begin
    rd_data_val_o = '0;
    for (int k = 0; k < ENGINES_CNT; k++) begin
      rd_data_val_o[k] = ret_val && (ret_id == ID_W'(k));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
    end else if (rd_en_o && !ret_val) begin
      inflight_q <= inflight_q + 1'b1;
    end else if (!rd_en_o && ret_val) begin
      inflight_q <= inflight_q - 1'b1;
    end
  end

  assign inflight_o = inflight_q;
  assign idle_o     = (req_i == '0) && (inflight_q == '0);

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));
  a_gnt_req    : assert property (@(posedge clk_i) disable iff (rst_i)
    (gnt_o & ~req_i) == '0);
  a_busy_block : assert property (@(posedge clk_i) disable iff (rst_i)
    wr_busy_i |-> !rd_en_o);
  a_val_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(rd_data_val_o));
  a_inflight   : assert property (@(posedge clk_i) disable iff (rst_i)
    inflight_q <= CNT_W'(RAM_LATENCY));

endmodule

// File: tb/tb_data_table_rd_arbiter.sv
// Scoreboard bench: a round-robin model predicts grants and queues returns,
// and a monitor matches every data-valid strobe against that queue.
module tb_data_table_rd_arbiter;

  localparam int E  = 3;
  localparam int L  = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int CW = $clog2(L + 1);

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [E-1:0]      req_i;
  logic [E*AW-1:0]   addr_i;
  logic [E-1:0]      gnt_o;
  logic              wr_busy_i;
  logic              rd_en_o;
  logic [AW-1:0]     rd_addr_o;
  logic [DW-1:0]     rd_data_i;
  logic [DW-1:0]     rd_data_o;
  logic [E-1:0]      rd_data_val_o;
  logic [CW-1:0]     inflight_o;
  logic              idle_o;

  always #5 clk_i = ~clk_i;

  data_table_rd_arbiter #(
    .ENGINES_CNT(E), .RAM_LATENCY(L), .A_WIDTH(AW), .D_WIDTH(DW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i),
    .gnt_o(gnt_o), .wr_busy_i(wr_busy_i), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i), .rd_data_o(rd_data_o),
    .rd_data_val_o(rd_data_val_o), .inflight_o(inflight_o), .idle_o(idle_o)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  ret_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cycle  = 0;
  int            last_gnt = E - 1;
  logic [E-1:0]  model_gnt = '0;
  logic [AW-1:0] addr_m [E];
  int            waitc  [E];
  logic [AW-1:0] ram_pipe [L];

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A5_0000;
  endfunction

  // Behavioural RAM: the word at the issued address appears L cycles later.
  always @(posedge clk_i) begin
    cycle       <= cycle + 1;
    ram_pipe[0] <= rd_addr_o;
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign rd_data_i = ram_word(ram_pipe[L-1]);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  task automatic checkOutput();
    int            exp_id;
    logic [E-1:0]  exp_gnt;
    logic [AW-1:0] exp_addr;
    exp_id   = -1;
    exp_gnt  = '0;
    exp_addr = '0;
    if (!wr_busy_i) begin
      for (int s = 1; s <= E; s++) begin
        int k;
        k = (last_gnt + s) % E;
        if (exp_id < 0 && req_i[k]) exp_id = k;
      end
    end
    if (exp_id >= 0) begin
      exp_gnt[exp_id] = 1'b1;
      exp_addr        = addr_m[exp_id];
    end
    check("gnt", gnt_o, exp_gnt);
    check("rd_en", rd_en_o, exp_id >= 0);
    check("rd_addr", rd_addr_o, exp_addr);
    check("inflight", inflight_o, sb.size());
    check("idle", idle_o, (req_i == '0) && (sb.size() == 0));
    for (int k = 0; k < E; k++) begin
      if (gnt_o[k]) begin
        check("wait_bound", waitc[k] <= E - 1, 1);
        waitc[k] = 0;
      end else if (req_i[k] && !wr_busy_i) begin
        waitc[k]++;
      end
    end
    model_gnt = exp_gnt;
    if (exp_id >= 0) begin
      last_gnt = exp_id;
      sb.push_back('{exp_id, ram_word(exp_addr), cycle + L});
    end
  endtask

  task automatic applyStimulus(input logic [E-1:0] req, input logic busy);
    req_i     = req;
    wr_busy_i = busy;
    for (int k = 0; k < E; k++) addr_i[k*AW +: AW] = addr_m[k];
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < E; k++)
      if (model_gnt[k]) addr_m[k] = AW'($urandom);
  endtask

  task automatic doReset();
    rst_i     = 1'b1;
    req_i     = '0;
    wr_busy_i = 1'b0;
    sb.delete();
    last_gnt  = E - 1;
    model_gnt = '0;
    for (int k = 0; k < E; k++) waitc[k] = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_inflight", inflight_o, 0);
    check("reset_val", rd_data_val_o, 0);
    check("reset_gnt", gnt_o, 0);
    rst_i = 1'b0;
  endtask

  // Monitor: pops one expected return per observed strobe.
  initial begin
    ret_t r;
    forever begin
      @(negedge clk_i);
      #2;
      if (rd_data_val_o !== '0) begin
        if (sb.size() == 0) begin
          check("spurious_val", rd_data_val_o, 0);
        end else begin
          r = sb.pop_front();
          check("val_id", rd_data_val_o, E'(1) << r.id);
          check("val_cycle", cycle, r.due);
          check("rd_data", rd_data_o, r.data);
        end
      end else if (sb.size() > 0 && sb[0].due <= cycle) begin
        r = sb.pop_front();
        check("val_missing", rd_data_val_o, E'(1) << r.id);
      end
    end
  end

  initial begin
    logic [E-1:0] nreq;
    rst_i     = 1'b1;
    req_i     = '0;
    wr_busy_i = 1'b0;
    addr_i    = '0;
    for (int k = 0; k < E; k++) begin
      addr_m[k] = AW'($urandom);
      waitc[k]  = 0;
    end
    doReset();
    applyStimulus(3'b000, 1'b0);

    addr_m[0] = 10'h010;
    applyStimulus(3'b001, 1'b0);
    repeat (3) applyStimulus(3'b000, 1'b0);

    repeat (6) applyStimulus(3'b111, 1'b0);
    repeat (3) applyStimulus(3'b000, 1'b0);

    applyStimulus(3'b010, 1'b0);
    repeat (3) applyStimulus(3'b110, 1'b0);
    repeat (3) applyStimulus(3'b000, 1'b0);

    applyStimulus(3'b011, 1'b0);
    repeat (3) applyStimulus(3'b011, 1'b1);
    applyStimulus(3'b011, 1'b0);
    repeat (3) applyStimulus(3'b000, 1'b0);

    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b010, 1'b0);
    doReset();
    repeat (4) applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b101, 1'b0);
    repeat (3) applyStimulus(3'b000, 1'b0);

    for (int c = 0; c < 1000; c++) begin
      if (c == 500) doReset();
      for (int k = 0; k < E; k++)
        nreq[k] = (req_i[k] && !model_gnt[k]) ? 1'b1 : ($urandom_range(0, 99) < 55);
      applyStimulus(nreq, $urandom_range(0, 99) < 12);
    end

    repeat (5) applyStimulus(3'b000, 1'b0);
    check("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
